// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : access-size encodings, byte-lane count and response FSM states
// Rev 1.0
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int unsigned LANES = 4;

    typedef logic [0:0] state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_FULL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/memory_array.sv
`default_nettype none
// ============================================================================
// memory_array : DEPTH x 32 storage, byte write-enables, combinational read
// Rev 1.0
// ============================================================================
module memory_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [LANES-1:0] be_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    // Contents start at zero and are deliberately untouched by reset.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/memory_unit.sv
`default_nettype none
// ============================================================================
// memory_unit : byte/half/word load-store unit with a one-entry response slot
// Option macro MEMORY_UNIT_MISALIGN_TRAP_EN: misaligned half/word faults
// instead of being forced down to natural alignment.
// Rev 1.0
// ============================================================================
module memory_unit
    import mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             accept, drain, mem_we;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    logic             out_of_range, misalign, req_err;
    logic [LANES-1:0] be;
    logic [4:0]       shamt;
    logic [31:0]      wdata_lanes, rd_word, rd_shift, load_data;

    assign word_idx     = req_addr[2 +: IDX_W];
    assign out_of_range = |req_addr[ADDR_W-1:2+IDX_W];

`ifdef MEMORY_UNIT_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                      ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
    assign offset   = req_addr[1:0];
`else
    assign misalign = 1'b0;
    always_comb begin
        offset = req_addr[1:0];
        if (req_size == SIZE_H) begin
            offset[0] = 1'b0;
        end else if (req_size == SIZE_W) begin
            offset = 2'b00;
        end
    end
`endif

    assign req_err = out_of_range || misalign || (req_size == 2'd3);
    assign shamt   = {offset, 3'b000};

    always_comb begin
        case (req_size)
            SIZE_B:  be = 4'b0001 << offset;
            SIZE_H:  be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
    end

    assign wdata_lanes = req_wdata << shamt;
    assign accept      = req_valid && req_ready;
    assign drain       = rsp_valid && rsp_ready;
    // A store landing on the same edge as reset is dropped.
    assign mem_we      = accept && req_we && !req_err && !rst;

    memory_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (be),
        .addr_i  (word_idx),
        .wdata_i (wdata_lanes),
        .rdata_o (rd_word)
    );

    assign rd_shift = rd_word >> shamt;

    always_comb begin
        case (req_size)
            SIZE_B:  load_data = {{24{!req_unsigned && rd_shift[7]}},  rd_shift[7:0]};
            SIZE_H:  load_data = {{16{!req_unsigned && rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            state_d = ST_FULL;
            err_d   = req_err;
            rdata_d = (req_we || req_err) ? 32'h0 : load_data;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign req_ready = !rsp_valid || rsp_ready;

endmodule
`default_nettype wire
